// File: rtl/pe_sparse_row_conv.sv
// Sparse row-convolution PE: loads a compressed weight list, scatters IA x W products into a
// COL x K saturating psum buffer, then drains requantised (shift, saturate, optional ReLU) outputs.
module pe_sparse_row_conv #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int COL    = 16,
  parameter int K      = 8,
  parameter int C_W    = 5,
  parameter int R      = 3,
  parameter int NW_MAX = 64,
  parameter int SHIFT  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_relu,
  input  logic [$clog2(NW_MAX+1)-1:0]   i_w_cnt,
  input  logic                          i_w_valid,
  output logic                          o_w_ready,
  input  logic [DATA_W-1:0]             i_w_data,
  input  logic [C_W-1:0]                i_w_c,
  input  logic [$clog2(R)-1:0]          i_w_r,
  input  logic [$clog2(K)-1:0]          i_w_k,
  input  logic                          i_ia_valid,
  output logic                          o_ia_ready,
  input  logic [DATA_W-1:0]             i_ia_data,
  input  logic [C_W-1:0]                i_ia_c,
  input  logic [$clog2(COL)-1:0]        i_ia_w,
  input  logic                          i_ia_last,
  output logic                          o_oa_valid,
  input  logic                          i_oa_ready,
  output logic [DATA_W-1:0]             o_oa_data,
  output logic [$clog2(COL)-1:0]        o_oa_x,
  output logic [$clog2(K)-1:0]          o_oa_k,
  output logic                          o_oa_last,
  output logic                          o_busy,
  output logic                          o_finish
);
  localparam int unsigned WC_W = $clog2(NW_MAX+1);
  localparam int unsigned WI_W = $clog2(NW_MAX);
  localparam int unsigned XW   = $clog2(COL);
  localparam int unsigned KW   = $clog2(K);
  localparam int unsigned RW   = $clog2(R);
  localparam int          PAD  = (R-1)/2;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD_W, S_PROC, S_DRAIN, S_DONE} state_t;
  state_t state;

  logic                     relu_q;
  logic [WC_W-1:0]          n_w, w_idx, scan_idx;
  logic [XW-1:0]            clr_cnt, dx, nx;
  logic [KW-1:0]            dk, nk;
  logic                     scan_busy, ia_last_q;
  logic signed [DATA_W-1:0] ia_data_q;
  logic [C_W-1:0]           ia_c_q;
  logic [XW-1:0]            ia_w_q;

  logic signed [DATA_W-1:0] wm_data [NW_MAX];
  logic [C_W-1:0]           wm_c    [NW_MAX];
  logic [RW-1:0]            wm_r    [NW_MAX];
  logic [KW-1:0]            wm_k    [NW_MAX];
  logic signed [ACC_W-1:0]  psum    [COL][K];

  logic signed [DATA_W-1:0]   cur_w;
  logic [C_W-1:0]             cur_c;
  logic [RW-1:0]              cur_r;
  logic [KW-1:0]              cur_k;
  int                         ox_i;
  logic                       hit, scan_last;
  logic [XW-1:0]              ox_idx;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      sum;
  logic signed [ACC_W-1:0]    acc_next;

  assign o_busy     = (state != S_IDLE);
  assign o_finish   = (state == S_DONE);
  assign o_w_ready  = (state == S_LOAD_W);
  assign o_ia_ready = (state == S_PROC) && !scan_busy;

  // The psum update reads and writes the register array in the same cycle, so back-to-back
  // hits on one (ox,k) always see the previous sum without forwarding.
  always_comb begin
    cur_w     = wm_data[scan_idx[WI_W-1:0]];
    cur_c     = wm_c[scan_idx[WI_W-1:0]];
    cur_r     = wm_r[scan_idx[WI_W-1:0]];
    cur_k     = wm_k[scan_idx[WI_W-1:0]];
    ox_i      = int'(ia_w_q) + PAD - int'(cur_r);
    ox_idx    = XW'(ox_i);
    hit       = scan_busy && (n_w != '0) && (cur_c == ia_c_q) && (ox_i >= 0) && (ox_i < COL);
    prod      = (2*DATA_W)'(ia_data_q) * (2*DATA_W)'(cur_w);
    sum       = (ACC_W+1)'(psum[ox_idx][cur_k]) + (ACC_W+1)'(prod);
    acc_next  = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1])
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    scan_last = (n_w == '0) || (scan_idx == n_w - WC_W'(1));
    nx        = dx;
    nk        = dk + KW'(1);
    if (dk == KW'(K-1)) begin
      nk = '0;
      nx = dx + XW'(1);
    end
  end

  function automatic logic signed [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] p,
                                                       input logic relu);
    logic signed [ACC_W-1:0]  s;
    logic signed [DATA_W-1:0] r;
    s = p >>> SHIFT;
    if (s[ACC_W-1:DATA_W-1] == '0 || s[ACC_W-1:DATA_W-1] == '1)
      r = s[DATA_W-1:0];
    else
      r = s[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    if (relu && r[DATA_W-1])
      r = '0;
    return r;
  endfunction

  always_ff @(posedge i_clk) begin
    if (state == S_LOAD_W && i_w_valid) begin
      wm_data[w_idx[WI_W-1:0]] <= i_w_data;
      wm_c[w_idx[WI_W-1:0]]    <= i_w_c;
      wm_r[w_idx[WI_W-1:0]]    <= i_w_r;
      wm_k[w_idx[WI_W-1:0]]    <= i_w_k;
    end
    if (state == S_CLEAR)
      for (int unsigned kk = 0; kk < K; kk++) psum[clr_cnt][KW'(kk)] <= '0;
    if (state == S_PROC && hit)
      psum[ox_idx][cur_k] <= acc_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      relu_q     <= 1'b0;
      n_w        <= '0;
      w_idx      <= '0;
      scan_idx   <= '0;
      clr_cnt    <= '0;
      scan_busy  <= 1'b0;
      ia_last_q  <= 1'b0;
      ia_data_q  <= '0;
      ia_c_q     <= '0;
      ia_w_q     <= '0;
      dx         <= '0;
      dk         <= '0;
      o_oa_valid <= 1'b0;
      o_oa_data  <= '0;
      o_oa_x     <= '0;
      o_oa_k     <= '0;
      o_oa_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          relu_q    <= i_relu;
          n_w       <= (i_w_cnt > WC_W'(NW_MAX)) ? WC_W'(NW_MAX) : i_w_cnt;
          clr_cnt   <= '0;
          scan_busy <= 1'b0;
          state     <= S_CLEAR;
        end
        S_CLEAR: begin
          clr_cnt <= clr_cnt + XW'(1);
          if (clr_cnt == XW'(COL-1)) begin
            w_idx <= '0;
            state <= (n_w == '0) ? S_PROC : S_LOAD_W;
          end
        end
        S_LOAD_W: if (i_w_valid) begin
          w_idx <= w_idx + WC_W'(1);
          if (w_idx == n_w - WC_W'(1)) state <= S_PROC;
        end
        S_PROC: if (!scan_busy) begin
          if (i_ia_valid) begin
            ia_data_q <= i_ia_data;
            ia_c_q    <= i_ia_c;
            ia_w_q    <= i_ia_w;
            ia_last_q <= i_ia_last;
            scan_idx  <= '0;
            scan_busy <= 1'b1;
          end
        end else begin
          scan_idx <= scan_idx + WC_W'(1);
          if (scan_last) begin
            scan_busy <= 1'b0;
            if (ia_last_q) begin
              dx    <= '0;
              dk    <= '0;
              state <= S_DRAIN;
            end
          end
        end
        // The first beat is loaded one cycle after entry so the final scan write has landed.
        S_DRAIN: if (!o_oa_valid) begin
          o_oa_valid <= 1'b1;
          o_oa_data  <= requant(psum[dx][dk], relu_q);
          o_oa_x     <= dx;
          o_oa_k     <= dk;
          o_oa_last  <= (dx == XW'(COL-1)) && (dk == KW'(K-1));
        end else if (i_oa_ready) begin
          if (o_oa_last) begin
            o_oa_valid <= 1'b0;
            o_oa_last  <= 1'b0;
            state      <= S_DONE;
          end else begin
            dx        <= nx;
            dk        <= nk;
            o_oa_data <= requant(psum[nx][nk], relu_q);
            o_oa_x    <= nx;
            o_oa_k    <= nk;
            o_oa_last <= (nx == XW'(COL-1)) && (nk == KW'(K-1));
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_sparse_row_conv.sv
// Randomised and directed jobs for pe_sparse_row_conv, checked beat-by-beat against an
// arithmetic model of the sparse convolution, saturation and requantisation rules.
module tb_pe_sparse_row_conv;
  localparam int COLN = 16;
  localparam int KN   = 8;
  localparam int NB   = COLN * KN;
  localparam int SH   = 4;
  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  logic        i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_relu = 1'b0;
  logic [6:0]  i_w_cnt = '0;
  logic        i_w_valid = 1'b0, o_w_ready;
  logic [15:0] i_w_data = '0;
  logic [4:0]  i_w_c = '0;
  logic [1:0]  i_w_r = '0;
  logic [2:0]  i_w_k = '0;
  logic        i_ia_valid = 1'b0, o_ia_ready;
  logic [15:0] i_ia_data = '0;
  logic [4:0]  i_ia_c = '0;
  logic [3:0]  i_ia_w = '0;
  logic        i_ia_last = 1'b0;
  logic        o_oa_valid, i_oa_ready = 1'b0;
  logic [15:0] o_oa_data;
  logic [3:0]  o_oa_x;
  logic [2:0]  o_oa_k;
  logic        o_oa_last, o_busy, o_finish;

  pe_sparse_row_conv #(.DATA_W(16), .ACC_W(32), .COL(COLN), .K(KN), .C_W(5), .R(3),
                       .NW_MAX(64), .SHIFT(SH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_relu(i_relu), .i_w_cnt(i_w_cnt),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data), .i_w_c(i_w_c),
    .i_w_r(i_w_r), .i_w_k(i_w_k), .i_ia_valid(i_ia_valid), .o_ia_ready(o_ia_ready),
    .i_ia_data(i_ia_data), .i_ia_c(i_ia_c), .i_ia_w(i_ia_w), .i_ia_last(i_ia_last),
    .o_oa_valid(o_oa_valid), .i_oa_ready(i_oa_ready), .o_oa_data(o_oa_data), .o_oa_x(o_oa_x),
    .o_oa_k(o_oa_k), .o_oa_last(o_oa_last), .o_busy(o_busy), .o_finish(o_finish));

  always #5 i_clk = ~i_clk;

  int vectors = 0, miscompares = 0;

  // current job description
  int nw, w_cnt_field, n_ia, ready_pct;
  bit relu_j;
  int wd[64], wc[64], wr[64], wk[64];
  int iad[64], iac[64], iaw[64];

  // captured drain and expected values
  int cap_data[NB], cap_x[NB], cap_k[NB];
  bit cap_last[NB];
  int cap_n;
  bit fin_seen, idle_after;
  int exp_data[NB];

  task automatic compute_expected();
    longint p[COLN][KN];
    longint v;
    for (int x = 0; x < COLN; x++) for (int k = 0; k < KN; k++) p[x][k] = 0;
    for (int i = 0; i < n_ia; i++)
      for (int j = 0; j < nw; j++)
        if (wc[j] == iac[i]) begin
          int ox;
          ox = iaw[i] + 1 - wr[j];
          if (ox >= 0 && ox < COLN) begin
            v = p[ox][wk[j]] + longint'(iad[i]) * longint'(wd[j]);
            if (v > AMAX) v = AMAX;
            if (v < AMIN) v = AMIN;
            p[ox][wk[j]] = v;
          end
        end
    for (int x = 0; x < COLN; x++)
      for (int k = 0; k < KN; k++) begin
        v = p[x][k] >>> SH;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        if (relu_j && v < 0) v = 0;
        exp_data[x*KN + k] = int'(v);
      end
  endtask

  task automatic rand_job(input int n_w, input int n_i);
    nw = n_w; w_cnt_field = n_w; n_ia = n_i;
    relu_j = 1'($urandom_range(1));
    for (int j = 0; j < nw; j++) begin
      wd[j] = int'($urandom_range(600)) - 300;
      wc[j] = int'($urandom_range(3));
      wr[j] = int'($urandom_range(2));
      wk[j] = int'($urandom_range(7));
    end
    for (int i = 0; i < n_ia; i++) begin
      iad[i] = int'($urandom_range(600)) - 300;
      iac[i] = int'($urandom_range(3));
      iaw[i] = int'($urandom_range(15));
    end
  endtask

  // Drives one job and records drained beats; abort_after >= 0 asserts reset before that IA entry.
  task automatic run_job(input int abort_after);
    int t;
    cap_n = 0; fin_seen = 0; idle_after = 0;
    @(negedge i_clk);
    i_start = 1'b1; i_relu = relu_j; i_w_cnt = 7'(w_cnt_field);
    @(negedge i_clk);
    i_start = 1'b0;
    for (int j = 0; j < nw; j++) begin
      if ($urandom_range(3) == 0) begin i_w_valid = 1'b0; @(negedge i_clk); end
      i_w_valid = 1'b1; i_w_data = 16'(wd[j]); i_w_c = 5'(wc[j]); i_w_r = 2'(wr[j]); i_w_k = 3'(wk[j]);
      t = 0;
      while (!o_w_ready && t < 200) begin @(negedge i_clk); t++; end
      @(negedge i_clk);
    end
    i_w_valid = 1'b0;
    for (int i = 0; i < n_ia; i++) begin
      if (i == abort_after) begin
        i_ia_valid = 1'b0; i_rst = 1'b1;
        @(negedge i_clk);
        return;
      end
      if ($urandom_range(3) == 0) begin i_ia_valid = 1'b0; @(negedge i_clk); end
      i_ia_valid = 1'b1; i_ia_data = 16'(iad[i]); i_ia_c = 5'(iac[i]); i_ia_w = 4'(iaw[i]);
      i_ia_last = (i == n_ia - 1);
      t = 0;
      while (!o_ia_ready && t < 200) begin @(negedge i_clk); t++; end
      @(negedge i_clk);
    end
    i_ia_valid = 1'b0; i_ia_last = 1'b0;
    t = 0;
    while (cap_n < NB && t < 4000) begin
      i_oa_ready = ($urandom_range(99) < ready_pct);
      if (o_oa_valid && i_oa_ready) begin
        cap_data[cap_n] = int'($signed(o_oa_data));
        cap_x[cap_n] = int'(o_oa_x);
        cap_k[cap_n] = int'(o_oa_k);
        cap_last[cap_n] = o_oa_last;
        cap_n++;
      end
      @(negedge i_clk);
      t++;
    end
    fin_seen = o_finish;
    i_oa_ready = 1'b0;
    @(negedge i_clk);
    idle_after = !o_busy;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    vectors++;
    if ({o_busy, o_finish, o_w_ready, o_ia_ready, o_oa_valid, o_oa_last} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, want 000000",
               {o_busy, o_finish, o_w_ready, o_ia_ready, o_oa_valid, o_oa_last});
    end
    vectors++;
    if ({o_oa_data, o_oa_x, o_oa_k} !== 23'b0) begin
      miscompares++;
      $display("FAIL reset_data: got d=%h x=%0d k=%0d, want 0", o_oa_data, o_oa_x, o_oa_k);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_single_weight();
    nw = 1; w_cnt_field = 1; n_ia = 1; relu_j = 0; ready_pct = 100;
    wd[0] = 3; wc[0] = 0; wr[0] = 1; wk[0] = 2;
    iad[0] = 4000; iac[0] = 0; iaw[0] = 5;
    compute_expected();
    run_job(-1);
    vectors++;
    if (cap_n !== NB || fin_seen !== 1'b1 || idle_after !== 1'b1) begin
      miscompares++;
      $display("FAIL single_count: got beats=%0d fin=%0b idle=%0b, want %0d 1 1", cap_n, fin_seen, idle_after, NB);
    end
    vectors++;
    if (cap_data[5*KN+2] !== 750) begin
      miscompares++;
      $display("FAIL single_oa52: got %0d, want 750", cap_data[5*KN+2]);
    end
    for (int b = 0; b < cap_n; b++) begin
      vectors++;
      if (cap_data[b] !== exp_data[b] || cap_x[b] !== b/KN || cap_k[b] !== b%KN || cap_last[b] !== (b == NB-1)) begin
        miscompares++;
        $display("FAIL single_beat%0d: got x=%0d k=%0d d=%0d last=%0b, want x=%0d k=%0d d=%0d last=%0b",
                 b, cap_x[b], cap_k[b], cap_data[b], cap_last[b], b/KN, b%KN, exp_data[b], b == NB-1);
      end
    end
  endtask

  task automatic test_edge_taps();
    nw = 2; w_cnt_field = 2; n_ia = 2; relu_j = 0; ready_pct = 100;
    wd[0] = 100; wc[0] = 1; wr[0] = 2; wk[0] = 1;
    wd[1] = 50;  wc[1] = 1; wr[1] = 0; wk[1] = 3;
    iad[0] = 20; iac[0] = 1; iaw[0] = 0;
    iad[1] = 30; iac[1] = 1; iaw[1] = COLN-1;
    compute_expected();
    run_job(-1);
    vectors++;
    if (cap_n !== NB || fin_seen !== 1'b1 || cap_data[1*KN+3] !== 62 || cap_data[14*KN+1] !== 187) begin
      miscompares++;
      $display("FAIL edge_taps: got beats=%0d fin=%0b oa13=%0d oa141=%0d, want %0d 1 62 187",
               cap_n, fin_seen, cap_data[1*KN+3], cap_data[14*KN+1], NB);
    end
    for (int b = 0; b < cap_n; b++) begin
      vectors++;
      if (cap_data[b] !== exp_data[b] || cap_x[b] !== b/KN || cap_k[b] !== b%KN || cap_last[b] !== (b == NB-1)) begin
        miscompares++;
        $display("FAIL edge_beat%0d: got x=%0d k=%0d d=%0d, want x=%0d k=%0d d=%0d",
                 b, cap_x[b], cap_k[b], cap_data[b], b/KN, b%KN, exp_data[b]);
      end
    end
  endtask

  task automatic test_saturation();
    nw = 1; w_cnt_field = 1; n_ia = 4; relu_j = 0; ready_pct = 100;
    wd[0] = 32767; wc[0] = 0; wr[0] = 1; wk[0] = 0;
    for (int i = 0; i < 4; i++) begin iad[i] = 32767; iac[i] = 0; iaw[i] = 3; end
    compute_expected();
    run_job(-1);
    vectors++;
    if (cap_n !== NB || cap_data[3*KN] !== 32767 || cap_data[3*KN+1] !== 0) begin
      miscompares++;
      $display("FAIL saturation: got beats=%0d oa30=%0d oa31=%0d, want %0d 32767 0",
               cap_n, cap_data[3*KN], cap_data[3*KN+1], NB);
    end
    for (int b = 0; b < cap_n; b++) begin
      vectors++;
      if (cap_data[b] !== exp_data[b] || cap_x[b] !== b/KN || cap_k[b] !== b%KN) begin
        miscompares++;
        $display("FAIL sat_beat%0d: got d=%0d, want d=%0d", b, cap_data[b], exp_data[b]);
      end
    end
  endtask

  task automatic test_relu();
    for (int r = 0; r < 2; r++) begin
      nw = 1; w_cnt_field = 1; n_ia = 1; relu_j = r[0]; ready_pct = 100;
      wd[0] = -8; wc[0] = 2; wr[0] = 0; wk[0] = 5;
      iad[0] = 12; iac[0] = 2; iaw[0] = 6;
      compute_expected();
      run_job(-1);
      vectors++;
      if (cap_n !== NB || cap_data[7*KN+5] !== (r == 1 ? 0 : -6)) begin
        miscompares++;
        $display("FAIL relu%0d: got beats=%0d oa75=%0d, want %0d %0d", r, cap_n, cap_data[7*KN+5], NB, r == 1 ? 0 : -6);
      end
      for (int b = 0; b < cap_n; b++) begin
        vectors++;
        if (cap_data[b] !== exp_data[b]) begin
          miscompares++;
          $display("FAIL relu%0d_beat%0d: got d=%0d, want d=%0d", r, b, cap_data[b], exp_data[b]);
        end
      end
    end
  endtask

  task automatic test_zero_weights();
    rand_job(0, 3);
    ready_pct = 70;
    compute_expected();
    run_job(-1);
    vectors++;
    if (cap_n !== NB || fin_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_w_count: got beats=%0d fin=%0b, want %0d 1", cap_n, fin_seen, NB);
    end
    for (int b = 0; b < cap_n; b++) begin
      vectors++;
      if (cap_data[b] !== 0 || cap_x[b] !== b/KN || cap_k[b] !== b%KN) begin
        miscompares++;
        $display("FAIL zero_w_beat%0d: got x=%0d k=%0d d=%0d, want x=%0d k=%0d d=0", b, cap_x[b], cap_k[b], cap_data[b], b/KN, b%KN);
      end
    end
  endtask

  task automatic test_weight_clamp();
    rand_job(64, 4);
    w_cnt_field = 100;
    ready_pct = 80;
    compute_expected();
    run_job(-1);
    vectors++;
    if (cap_n !== NB || fin_seen !== 1'b1 || idle_after !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_count: got beats=%0d fin=%0b idle=%0b, want %0d 1 1", cap_n, fin_seen, idle_after, NB);
    end
    for (int b = 0; b < cap_n; b++) begin
      vectors++;
      if (cap_data[b] !== exp_data[b] || cap_x[b] !== b/KN || cap_k[b] !== b%KN) begin
        miscompares++;
        $display("FAIL clamp_beat%0d: got d=%0d, want d=%0d", b, cap_data[b], exp_data[b]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 4; n++) begin
      rand_job(int'($urandom_range(1, 24)), int'($urandom_range(1, 12)));
      ready_pct = 25 + 20 * n;
      compute_expected();
      run_job(-1);
      vectors++;
      if (cap_n !== NB || fin_seen !== 1'b1 || idle_after !== 1'b1) begin
        miscompares++;
        $display("FAIL bp%0d_count: got beats=%0d fin=%0b idle=%0b, want %0d 1 1", n, cap_n, fin_seen, idle_after, NB);
      end
      for (int b = 0; b < cap_n; b++) begin
        vectors++;
        if (cap_data[b] !== exp_data[b] || cap_x[b] !== b/KN || cap_k[b] !== b%KN || cap_last[b] !== (b == NB-1)) begin
          miscompares++;
          $display("FAIL bp%0d_beat%0d: got x=%0d k=%0d d=%0d last=%0b, want x=%0d k=%0d d=%0d last=%0b",
                   n, b, cap_x[b], cap_k[b], cap_data[b], cap_last[b], b/KN, b%KN, exp_data[b], b == NB-1);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    rand_job(16, 5);
    for (int i = 0; i < 5; i++) iaw[i] = 8;
    ready_pct = 100;
    run_job(2);
    vectors++;
    if (o_busy !== 1'b0 || o_oa_valid !== 1'b0 || o_ia_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_idle: got busy=%0b oa_valid=%0b ia_ready=%0b, want 0 0 0", o_busy, o_oa_valid, o_ia_ready);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    rand_job(6, 2);
    ready_pct = 60;
    compute_expected();
    run_job(-1);
    vectors++;
    if (cap_n !== NB || fin_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_count: got beats=%0d fin=%0b, want %0d 1", cap_n, fin_seen, NB);
    end
    for (int b = 0; b < cap_n; b++) begin
      vectors++;
      if (cap_data[b] !== exp_data[b] || cap_x[b] !== b/KN || cap_k[b] !== b%KN) begin
        miscompares++;
        $display("FAIL midrst_beat%0d: got d=%0d, want d=%0d", b, cap_data[b], exp_data[b]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_weight();
    test_edge_taps();
    test_saturation();
    test_relu();
    test_zero_weights();
    test_weight_clamp();
    test_backpressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
